alu_instruction_encoder: RTL and testbench



---
 rtl/alu_isa_pkg.sv | 68 ++++++
 rtl/alu_word_packer.sv | 10 +
 rtl/alu_instruction_encoder.sv | 89 ++++++++
 tb/tb_alu_instruction_encoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_isa_pkg.sv
// alu_isa_pkg: ALU instruction word field layout, bundle type and word pack functions
package alu_isa_pkg;
   localparam int OP_LSB = 29;
   localparam int OP_W = 3;
   localparam int FORM_BIT = 28;
   localparam int CONST_BIT = 27;
   localparam int WR_LSB = 24;
   localparam int WR_W = 2;
   localparam int VP_LSB = 22;
   localparam int VP_W = 2;
   localparam int SEL_W = 4;
   localparam int A_LSB = 12;
   localparam int B_LSB = 8;
   localparam int C_LSB = 4;
   localparam int D_LSB = 0;
   localparam int Y1_LSB = 4;
   localparam int Y2_LSB = 0;
   localparam int K_W = 16;
   localparam logic [1:0] RESERVED_VP = 2'b11;

   typedef enum logic [1:0] {HEAD, YEXT, CEXT} word_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  vp;
      logic        form;
      logic        const_c;
      logic [15:0] constant;
      logic [1:0]  write;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [3:0]  c;
      logic [3:0]  d;
      logic [3:0]  y1;
      logic [3:0]  y2;
   } alu_bundle_t;

   // Write enables are stored inverted in the word (active-low in the decoder)
   function automatic logic [31:0] pack_head(alu_bundle_t bnd);
      logic [31:0] w;
      w = '0;
      w[OP_LSB +: OP_W] = bnd.op;
      w[FORM_BIT] = bnd.form;
      w[CONST_BIT] = bnd.const_c;
      w[WR_LSB +: WR_W] = ~bnd.write;
      w[VP_LSB +: VP_W] = bnd.vp;
      w[A_LSB +: SEL_W] = bnd.a;
      w[B_LSB +: SEL_W] = bnd.b;
      w[C_LSB +: SEL_W] = bnd.c;
      w[D_LSB +: SEL_W] = bnd.d;
      return w;
   endfunction

   function automatic logic [31:0] pack_yext(alu_bundle_t bnd);
      logic [31:0] w;
      w = '0;
      w[Y1_LSB +: SEL_W] = bnd.y1;
      w[Y2_LSB +: SEL_W] = bnd.y2;
      return w;
   endfunction

   function automatic logic [31:0] pack_cext(alu_bundle_t bnd);
      logic [31:0] w;
      w = '0;
      w[0 +: K_W] = bnd.constant;
      return w;
   endfunction
endpackage

// File: rtl/alu_word_packer.sv
// alu_word_packer: combinational pack of a latched bundle and word type into one 32-bit word
module alu_word_packer
   import alu_isa_pkg::*;
(
   input  alu_bundle_t bnd,
   input  word_t       wt,
   output logic [31:0] word
);
   always_comb word = wt == YEXT ? pack_yext(bnd) : wt == CEXT ? pack_cext(bnd) : pack_head(bnd);
endmodule

// File: rtl/alu_instruction_encoder.sv
// alu_instruction_encoder: emits 1-3 word ALU instructions from field bundles over valid/ready.
// Optional ALU_INSTRUCTION_ENCODER_STATS_EN adds instr_count/word_count outputs.
module alu_instruction_encoder
   import alu_isa_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  alu_op,
   input  logic [1:0]  alu_vec_perci,
   input  logic        alu_form,
   input  logic        const_c,
   input  logic [15:0] constant,
   input  logic [1:0]  alu_write,
   input  logic [3:0]  alu_a_select,
   input  logic [3:0]  alu_b_select,
   input  logic [3:0]  alu_c_select,
   input  logic [3:0]  alu_d_select,
   input  logic [3:0]  alu_Y1_select,
   input  logic [3:0]  alu_Y2_select,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic        out_last,
`ifdef ALU_INSTRUCTION_ENCODER_STATS_EN
   output logic [15:0] instr_count,
   output logic [15:0] word_count,
`endif
   output logic        err
);
   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_YEXT, S_CEXT} state_t;
   state_t state, state_n;
   alu_bundle_t bnd, bnd_n, in_bnd;
   word_t wt;
   logic [31:0] word_n;
   logic adv, acc, bad, last_n;
   assign in_bnd = '{op: alu_op, vp: alu_vec_perci, form: alu_form, const_c: const_c,
                     constant: constant, write: alu_write, a: alu_a_select, b: alu_b_select,
                     c: alu_c_select, d: alu_d_select, y1: alu_Y1_select, y2: alu_Y2_select};
   assign in_ready = state == S_IDLE || (out_last && out_ready);
   // Outputs are computed from the next state so they come straight from flops
   always_comb begin
      adv = out_valid && out_ready;
      acc = in_valid && in_ready;
      bad = alu_vec_perci == RESERVED_VP;
      state_n = state;
      bnd_n = bnd;
      if (adv)
         state_n = (state == S_HEAD && bnd.form) ? S_YEXT :
                   (state != S_CEXT && bnd.const_c) ? S_CEXT : S_IDLE;
      if (acc && !bad) begin
         state_n = S_HEAD;
         bnd_n = in_bnd;
      end
      wt = state_n == S_YEXT ? YEXT : state_n == S_CEXT ? CEXT : HEAD;
      last_n = state_n == S_HEAD ? !(bnd_n.form || bnd_n.const_c) :
               state_n == S_YEXT ? !bnd_n.const_c : state_n == S_CEXT;
   end
   alu_word_packer u_packer (.bnd(bnd_n), .wt(wt), .word(word_n));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         bnd <= '0;
         out_valid <= 1'b0;
         out_word <= '0;
         out_last <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         bnd <= bnd_n;
         out_valid <= state_n != S_IDLE;
         out_last <= last_n;
         err <= acc && bad;
         if (state_n != S_IDLE) out_word <= word_n;
      end
   end
`ifdef ALU_INSTRUCTION_ENCODER_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_count <= '0;
         word_count <= '0;
      end else begin
         if (adv && out_last) instr_count <= instr_count + 16'd1;
         if (adv) word_count <= word_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_instruction_encoder.sv
// tb_alu_instruction_encoder: directed self-checking bench for alu_instruction_encoder
module tb_alu_instruction_encoder;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [2:0] alu_op = '0;
   logic [1:0] alu_vec_perci = '0;
   logic alu_form = 1'b0;
   logic const_c = 1'b0;
   logic [15:0] constant = '0;
   logic [1:0] alu_write = '0;
   logic [3:0] alu_a_select = '0, alu_b_select = '0, alu_c_select = '0, alu_d_select = '0;
   logic [3:0] alu_Y1_select = '0, alu_Y2_select = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [31:0] out_word;
   logic out_last;
   logic err;
   int tests = 0;
   int fails = 0;
`ifdef ALU_INSTRUCTION_ENCODER_STATS_EN
   logic [15:0] instr_count, word_count;
`endif

   always #5 clk = ~clk;

   alu_instruction_encoder dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .alu_vec_perci(alu_vec_perci), .alu_form(alu_form), .const_c(const_c),
      .constant(constant), .alu_write(alu_write), .alu_a_select(alu_a_select),
      .alu_b_select(alu_b_select), .alu_c_select(alu_c_select), .alu_d_select(alu_d_select),
      .alu_Y1_select(alu_Y1_select), .alu_Y2_select(alu_Y2_select), .out_valid(out_valid),
      .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
`ifdef ALU_INSTRUCTION_ENCODER_STATS_EN
      .instr_count(instr_count), .word_count(word_count),
`endif
      .err(err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bundle(input logic [2:0] op, input logic [1:0] vp, input logic form,
                             input logic cc, input logic [15:0] k, input logic [1:0] wr,
                             input logic [15:0] abcd, input logic [7:0] y);
      alu_op = op; alu_vec_perci = vp; alu_form = form; const_c = cc; constant = k;
      alu_write = wr;
      {alu_a_select, alu_b_select, alu_c_select, alu_d_select} = abcd;
      {alu_Y1_select, alu_Y2_select} = y;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", out_valid); end
      tests++; if (out_word !== 32'h0) begin fails++; $display("FAIL rst_word got %h want 0", out_word); end
      tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_last got %b want 0", out_last); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      set_bundle(3'd0, 2'b10, 1'b0, 1'b0, 16'h0, 2'b11, 16'h1234, 8'h00);
      out_ready = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
      tests++; if (out_word !== 32'h00801234) begin fails++; $display("FAIL single_word got %h want 00801234", out_word); end
      tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL single_last got %b want 1", out_last); end
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_after got %b want 0", out_valid); end
   endtask

   task automatic test_three_word();
      set_bundle(3'd0, 2'b10, 1'b1, 1'b1, 16'hBEEF, 2'b11, 16'h1234, 8'h56);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      tests++; if (out_word !== 32'h18801234 || out_last !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL w3_head got %h last %b valid %b want 18801234 last 0 valid 1", out_word, out_last, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL w3_ready_head got %b want 0", in_ready); end
      step();
      tests++; if (out_word !== 32'h00000056 || out_last !== 1'b0) begin fails++; $display("FAIL w3_yext got %h last %b want 00000056 last 0", out_word, out_last); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL w3_ready_yext got %b want 0", in_ready); end
      step();
      tests++; if (out_word !== 32'h0000BEEF || out_last !== 1'b1) begin fails++; $display("FAIL w3_cext got %h last %b want 0000beef last 1", out_word, out_last); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL w3_ready_cext got %b want 1", in_ready); end
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL w3_after got %b want 0", out_valid); end
   endtask

   task automatic test_stall();
      set_bundle(3'd0, 2'b10, 1'b1, 1'b0, 16'h0, 2'b11, 16'h1234, 8'h56);
      out_ready = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests++; if (out_word !== 32'h10801234 || out_last !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL stall_%0d got %h last %b valid %b ready %b want 10801234 0 1 0", i, out_word, out_last, out_valid, in_ready); end
         step();
      end
      out_ready = 1'b1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_release_ready got %b want 0", in_ready); end
      step();
      tests++; if (out_word !== 32'h00000056 || out_last !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_yext got %h last %b valid %b want 00000056 1 1", out_word, out_last, out_valid); end
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_after got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      set_bundle(3'd1, 2'b10, 1'b0, 1'b0, 16'h0, 2'b11, 16'h1234, 8'h00);
      in_valid = 1'b1;
      step();
      tests++; if (out_valid !== 1'b1 || out_word !== 32'h20801234) begin fails++; $display("FAIL b2b_0 got %h valid %b want 20801234 1", out_word, out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", in_ready); end
      set_bundle(3'd2, 2'b01, 1'b0, 1'b0, 16'h0, 2'b01, 16'h5678, 8'h00);
      step();
      tests++; if (out_valid !== 1'b1 || out_word !== 32'h42405678) begin fails++; $display("FAIL b2b_1 got %h valid %b want 42405678 1", out_word, out_valid); end
      set_bundle(3'd7, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h9ABC, 8'h00);
      step();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || out_word !== 32'hE3009ABC || out_last !== 1'b1) begin fails++; $display("FAIL b2b_2 got %h valid %b last %b want e3009abc 1 1", out_word, out_valid, out_last); end
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_after got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      set_bundle(3'd3, 2'b11, 1'b0, 1'b0, 16'h0, 2'b11, 16'hAAAA, 8'h00);
      in_valid = 1'b1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ill_ready got %b want 1", in_ready); end
      step();
      tests++; if (out_valid !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL ill_err got valid %b err %b want 0 1", out_valid, err); end
      set_bundle(3'd0, 2'b10, 1'b0, 1'b0, 16'h0, 2'b11, 16'h1234, 8'h00);
      step();
      in_valid = 1'b0;
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_err_pulse got %b want 0", err); end
      tests++; if (out_valid !== 1'b1 || out_word !== 32'h00801234) begin fails++; $display("FAIL ill_next got %h valid %b want 00801234 1", out_word, out_valid); end
      step();
      tests++; if (out_valid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL ill_after got valid %b err %b want 0 0", out_valid, err); end
   endtask

   task automatic test_reset_mid();
      set_bundle(3'd0, 2'b10, 1'b1, 1'b1, 16'hBEEF, 2'b11, 16'h1234, 8'h56);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      tests++; if (out_word !== 32'h00000056) begin fails++; $display("FAIL mid_yext got %h want 00000056", out_word); end
      reset_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_async got valid %b ready %b want 0 1", out_valid, in_ready); end
`ifdef ALU_INSTRUCTION_ENCODER_STATS_EN
      tests++; if (instr_count !== 16'd0 || word_count !== 16'd0) begin fails++; $display("FAIL mid_counts got %0d %0d want 0 0", instr_count, word_count); end
`endif
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_resume_%0d got %b want 0", i, out_valid); end
      end
`ifdef ALU_INSTRUCTION_ENCODER_STATS_EN
      set_bundle(3'd0, 2'b10, 1'b0, 1'b0, 16'h0, 2'b11, 16'h1234, 8'h00);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      tests++; if (instr_count !== 16'd1 || word_count !== 16'd1) begin fails++; $display("FAIL stats_count got %0d %0d want 1 1", instr_count, word_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_three_word();
      test_stall();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
